// File: rtl/pulse_pkg.sv
// Shared definitions for the multi-channel pulse receiver.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Number of bits needed to hold values 0..v-1 (0 when v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_rx_ch.sv
// One receive channel: synchroniser, edge detect, pulse FSM, pending queue, overflow flag.
module pulse_rx_ch
  import pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 1,
  parameter int unsigned GAP_W       = 1,
  parameter int unsigned PEND_MAX    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic tgl_in,
  input  logic ovf_clr,
  output logic pulse_out,
  output logic busy,
  output logic ovf
);

  localparam int unsigned PEND_W  = clog2(PEND_MAX + 1);
  localparam int unsigned TMR_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned TMR_W   = clog2(TMR_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [PEND_W-1:0]      pend_q, pend_d;
  logic                   ovf_d;
  logic                   ev_c, idle_empty_c, inc_c, gap_done_c, deq_c, full_c, drop_c;

  // Toggle synchroniser and previous-level flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Next state, timer, pending count and overflow; a GAP expiry that coincides
  // with a fresh event restarts HIGH directly so the event is never parked in IDLE
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    pend_d       = pend_q;
    ovf_d        = ovf;
    ev_c         = arm & (sync_q[SYNC_STAGES-1] ^ prev_q);
    idle_empty_c = (state_q == ST_IDLE) && (pend_q == '0);
    inc_c        = ev_c && !idle_empty_c;
    gap_done_c   = (state_q == ST_GAP) && (tmr_q == TMR_W'(GAP_W - 1));
    deq_c        = gap_done_c && ((pend_q != '0) || inc_c);
    full_c       = (pend_q == PEND_W'(PEND_MAX));
    drop_c       = inc_c && !deq_c && full_c;

    case (state_q)
      ST_IDLE: begin
        if (ev_c && idle_empty_c) begin
          state_d = ST_HIGH;
          tmr_d   = '0;
        end
      end
      ST_HIGH: begin
        if (tmr_q == TMR_W'(PULSE_W - 1)) begin
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_done_c) begin
          state_d = deq_c ? ST_HIGH : ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase

    if (inc_c && !deq_c && !full_c) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (deq_c && !inc_c) begin
      pend_d = pend_q - PEND_W'(1);
    end

    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      pend_q    <= '0;
      ovf       <= 1'b0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      ovf       <= ovf_d;
      pulse_out <= (state_d == ST_HIGH);
      busy      <= (state_d != ST_IDLE) || (pend_d != '0);
    end
  end

endmodule

// File: rtl/pulse_rx_sync.sv
// Multi-channel toggle-to-pulse receiver with a shared post-reset arming window.
module pulse_rx_sync
  import pulse_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 1,
  parameter int unsigned GAP_W       = 1,
  parameter int unsigned PEND_MAX    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] tgl_in,
  output logic [N_CH-1:0] pulse_out,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr
);

  localparam int unsigned ARM_CNT = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = clog2(ARM_CNT + 1);

  logic [ARM_W-1:0] arm_cnt_q;
  logic             arm_c;

  assign arm_c = (arm_cnt_q == ARM_W'(ARM_CNT));

  // Count out the arming window after reset so stale levels do not look like events
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt_q <= '0;
    end else if (!arm_c) begin
      arm_cnt_q <= arm_cnt_q + ARM_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pulse_rx_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .PULSE_W    (PULSE_W),
      .GAP_W      (GAP_W),
      .PEND_MAX   (PEND_MAX)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm_c),
      .tgl_in   (tgl_in[g]),
      .ovf_clr  (ovf_clr[g]),
      .pulse_out(pulse_out[g]),
      .busy     (busy[g]),
      .ovf      (ovf[g])
    );
  end

endmodule

// File: tb/tb_pulse_rx_sync.sv
// Bench for pulse_rx_sync: directed scenarios plus random toggles against an event-schedule model.
module tb_pulse_rx_sync;

  localparam int S    = 2;
  localparam int PMAX = 3;
  localparam int NR   = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tgl, clr;
  logic [3:0] pulse, busy, ovf;
  logic [0:0] tgl2, clr2, pulse2, busy2, ovf2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_rx_sync dut (
    .clk(clk), .rst(rst), .tgl_in(tgl), .pulse_out(pulse),
    .busy(busy), .ovf(ovf), .ovf_clr(clr)
  );

  pulse_rx_sync #(.N_CH(1), .PULSE_W(3), .GAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .tgl_in(tgl2), .pulse_out(pulse2),
    .busy(busy2), .ovf(ovf2), .ovf_clr(clr2)
  );

  // Model: lanes 0..3 are dut channels, lane 4 is dut2 channel 0.
  // Each accepted event has a detect edge and a pulse start edge.
  int tev_a [5][NR];
  int st_a  [5][NR];
  int nrec  [5];
  int drop_a[5][NR];
  int ndrop [5];
  bit ovf_m [5];
  int rel_edge = 0;
  int checks = 0;
  int errors = 0;

  // Observed rising edges per lane
  int rise_e [5][16];
  int nrise  [5];
  int highcnt[5];
  bit prev_p [5];

  function automatic int pw_of(int l);  return (l == 4) ? 3 : 1; endfunction
  function automatic int gap_of(int l); return (l == 4) ? 2 : 1; endfunction

  // Schedule an event detected at edge t: start at t, or after the last pulse plus gap
  function automatic void model_event(int l, int t);
    int pend, last, s;
    bit deq;
    if (t <= rel_edge + S) return;
    pend = 0; deq = 0; last = -100;
    for (int i = 0; i < nrec[l]; i++) begin
      if (st_a[l][i] >= t) pend++;
      if (st_a[l][i] == t) deq = 1;
      if (st_a[l][i] > last) last = st_a[l][i];
    end
    if (pend >= PMAX && !deq) begin
      if (ndrop[l] < NR) begin drop_a[l][ndrop[l]] = t; ndrop[l]++; end
      return;
    end
    s = last + pw_of(l) + gap_of(l);
    if (s < t) s = t;
    if (nrec[l] < NR) begin tev_a[l][nrec[l]] = t; st_a[l][nrec[l]] = s; nrec[l]++; end
  endfunction

  function automatic bit exp_pulse(int l, int e);
    for (int i = 0; i < nrec[l]; i++)
      if (st_a[l][i] <= e && e < st_a[l][i] + pw_of(l)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_busy(int l, int e);
    for (int i = 0; i < nrec[l]; i++)
      if (tev_a[l][i] <= e && e < st_a[l][i] + pw_of(l) + gap_of(l)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_pulse_v();
    logic [3:0] v;
    for (int l = 0; l < 4; l++) v[l] = exp_pulse(l, cyc);
    return v;
  endfunction

  function automatic logic [3:0] exp_busy_v();
    logic [3:0] v;
    for (int l = 0; l < 4; l++) v[l] = exp_busy(l, cyc);
    return v;
  endfunction

  function automatic logic [3:0] exp_ovf_v();
    logic [3:0] v;
    for (int l = 0; l < 4; l++) v[l] = ovf_m[l];
    return v;
  endfunction

  function automatic logic obs_pulse(int l);
    return (l == 4) ? pulse2[0] : pulse[l];
  endfunction

  // Advance one clock (negedge to negedge) and update the model for the edge just taken
  task automatic tick();
    bit d, c;
    @(negedge clk);
    for (int l = 0; l < 5; l++) begin
      if (rst) begin
        nrec[l] = 0; ndrop[l] = 0; ovf_m[l] = 1'b0;
      end else begin
        d = 1'b0;
        for (int i = 0; i < ndrop[l]; i++) if (drop_a[l][i] == cyc) d = 1'b1;
        c = (l == 4) ? clr2[0] : clr[l];
        if (d) ovf_m[l] = 1'b1;
        else if (c) ovf_m[l] = 1'b0;
      end
      if (obs_pulse(l) === 1'b1) begin
        highcnt[l]++;
        if (!prev_p[l]) begin
          if (nrise[l] < 16) rise_e[l][nrise[l]] = cyc;
          nrise[l]++;
        end
      end
      prev_p[l] = (obs_pulse(l) === 1'b1);
    end
    if (rst) rel_edge = cyc + 1;
  endtask

  task automatic toggle(int l);
    if (l == 4) tgl2[0] = ~tgl2[0];
    else        tgl[l]  = ~tgl[l];
    model_event(l, cyc + 1 + S);
  endtask

  task automatic clear_obs();
    for (int l = 0; l < 5; l++) begin nrise[l] = 0; highcnt[l] = 0; end
  endtask

  task automatic test_reset();
    rst = 1'b1; tgl = 4'b1010; clr = '0; tgl2 = '0; clr2 = '0;
    tick();
    checks++;
    if ({pulse, busy, ovf, pulse2, busy2, ovf2} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {pulse, busy, ovf, pulse2, busy2, ovf2});
    end
    repeat (9) tick();
    rst = 1'b0;
    clear_obs();
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (pulse !== 4'b0000 || busy !== 4'b0000 || ovf !== 4'b0000) begin
        errors++; $display("FAIL arm_silent cyc %0d pulse %b busy %b ovf %b want 0", cyc, pulse, busy, ovf);
      end
    end
  endtask

  task automatic test_single();
    int k;
    clear_obs();
    toggle(0);
    k = cyc + 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (pulse !== exp_pulse_v() || busy !== exp_busy_v()) begin
        errors++; $display("FAIL single_model cyc %0d pulse %b busy %b want %b %b", cyc, pulse, busy, exp_pulse_v(), exp_busy_v());
      end
    end
    checks++;
    if (nrise[0] != 1 || rise_e[0][0] != k + 2 || highcnt[0] != 1) begin
      errors++; $display("FAIL single_timing rises %0d at %0d high %0d want 1 at %0d high 1", nrise[0], rise_e[0][0], highcnt[0], k + 2);
    end
    checks++;
    if (nrise[1] + nrise[2] + nrise[3] != 0) begin
      errors++; $display("FAIL single_others got %0d pulses want 0", nrise[1] + nrise[2] + nrise[3]);
    end
  endtask

  task automatic test_burst3();
    clear_obs();
    for (int i = 0; i < 3; i++) begin toggle(1); tick(); end
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (pulse !== exp_pulse_v() || busy !== exp_busy_v() || ovf !== exp_ovf_v()) begin
        errors++; $display("FAIL burst3_model cyc %0d pulse %b busy %b ovf %b want %b %b %b", cyc, pulse, busy, ovf, exp_pulse_v(), exp_busy_v(), exp_ovf_v());
      end
    end
    checks++;
    if (nrise[1] != 3 || rise_e[1][1] - rise_e[1][0] != 2 || rise_e[1][2] - rise_e[1][1] != 2) begin
      errors++; $display("FAIL burst3_spacing rises %0d at %0d %0d %0d want 3 spaced 2", nrise[1], rise_e[1][0], rise_e[1][1], rise_e[1][2]);
    end
    checks++;
    if (ovf[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL burst3_end ovf %b busy %b want 0 0", ovf[1], busy[1]);
    end
  endtask

  task automatic test_overflow();
    int t8;
    clear_obs();
    for (int i = 0; i < 8; i++) begin toggle(2); t8 = cyc + 1 + S; tick(); end
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (pulse !== exp_pulse_v() || busy !== exp_busy_v() || ovf !== exp_ovf_v()) begin
        errors++; $display("FAIL ovf_model cyc %0d pulse %b busy %b ovf %b want %b %b %b", cyc, pulse, busy, ovf, exp_pulse_v(), exp_busy_v(), exp_ovf_v());
      end
      if (cyc == t8 - 1 || cyc == t8) begin
        checks++;
        if (ovf[2] !== (cyc == t8)) begin
          errors++; $display("FAIL ovf_set_edge cyc %0d got %b want %b", cyc, ovf[2], cyc == t8);
        end
      end
    end
    checks++;
    if (nrise[2] != 7 || ovf[2] !== 1'b1) begin
      errors++; $display("FAIL ovf_count pulses %0d ovf %b want 7 1", nrise[2], ovf[2]);
    end
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    checks++;
    if (ovf[2] !== 1'b0 || ovf !== exp_ovf_v()) begin
      errors++; $display("FAIL ovf_clear got %b want 0 (model %b)", ovf[2], exp_ovf_v());
    end
  endtask

  task automatic test_coincident();
    clear_obs();
    toggle(0); toggle(3);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (pulse[0] !== pulse[3] || pulse[2:1] !== 2'b00 || pulse !== exp_pulse_v()) begin
        errors++; $display("FAIL coincident cyc %0d got %b want %b", cyc, pulse, exp_pulse_v());
      end
    end
    checks++;
    if (nrise[0] != 1 || nrise[3] != 1 || rise_e[0][0] != rise_e[3][0]) begin
      errors++; $display("FAIL coincident_rise ch0 %0d@%0d ch3 %0d@%0d want 1 each same edge", nrise[0], rise_e[0][0], nrise[3], rise_e[3][0]);
    end
  endtask

  task automatic test_wide();
    clear_obs();
    toggle(4); tick();
    toggle(4);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (pulse2[0] !== exp_pulse(4, cyc) || busy2[0] !== exp_busy(4, cyc)) begin
        errors++; $display("FAIL wide_model cyc %0d pulse %b busy %b want %b %b", cyc, pulse2[0], busy2[0], exp_pulse(4, cyc), exp_busy(4, cyc));
      end
    end
    checks++;
    if (nrise[4] != 2 || highcnt[4] != 6 || rise_e[4][1] - rise_e[4][0] != 5) begin
      errors++; $display("FAIL wide_shape rises %0d high %0d spacing %0d want 2 6 5", nrise[4], highcnt[4], rise_e[4][1] - rise_e[4][0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < 5; l++) begin
        if ($urandom_range(0, 99) < 30) toggle(l);
      end
      for (int l = 0; l < 4; l++) clr[l] = ($urandom_range(0, 99) < 4);
      clr2[0] = ($urandom_range(0, 99) < 4);
      tick();
      checks++;
      if (pulse !== exp_pulse_v() || busy !== exp_busy_v() || ovf !== exp_ovf_v()) begin
        errors++; $display("FAIL random cyc %0d pulse %b busy %b ovf %b want %b %b %b", cyc, pulse, busy, ovf, exp_pulse_v(), exp_busy_v(), exp_ovf_v());
      end
      checks++;
      if (pulse2[0] !== exp_pulse(4, cyc) || busy2[0] !== exp_busy(4, cyc) || ovf2[0] !== ovf_m[4]) begin
        errors++; $display("FAIL random_wide cyc %0d pulse %b busy %b ovf %b want %b %b %b", cyc, pulse2[0], busy2[0], ovf2[0], exp_pulse(4, cyc), exp_busy(4, cyc), ovf_m[4]);
      end
    end
    clr = '0; clr2 = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (pulse !== exp_pulse_v() || busy !== exp_busy_v() || ovf !== exp_ovf_v()) begin
        errors++; $display("FAIL drain cyc %0d pulse %b busy %b ovf %b want %b %b %b", cyc, pulse, busy, ovf, exp_pulse_v(), exp_busy_v(), exp_ovf_v());
      end
    end
  endtask

  task automatic test_rst_mid();
    clear_obs();
    for (int i = 0; i < 4; i++) begin toggle(1); tick(); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (pulse !== 4'b0 || busy !== 4'b0 || ovf !== 4'b0 || pulse2 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear pulse %b busy %b ovf %b want 0", pulse, busy, ovf);
    end
    repeat (2) tick();
    rst = 1'b0;
    clear_obs();
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++;
      if (pulse !== 4'b0 || busy !== 4'b0 || pulse !== exp_pulse_v()) begin
        errors++; $display("FAIL rst_mid_silent cyc %0d pulse %b busy %b want 0", cyc, pulse, busy);
      end
    end
  endtask

  initial begin
    for (int l = 0; l < 5; l++) begin nrec[l] = 0; ndrop[l] = 0; ovf_m[l] = 1'b0; prev_p[l] = 1'b0; end
    clear_obs();
    test_reset();
    test_single();
    repeat (5) tick();
    test_burst3();
    repeat (5) tick();
    test_overflow();
    repeat (5) tick();
    test_coincident();
    repeat (5) tick();
    test_wide();
    repeat (5) tick();
    test_random();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
